reg_bus_master: RTL

REG_BUS_MASTER -- requirements
Module: reg_bus_master

---
 rtl/reg_bus_master.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/reg_bus_master.sv
// reg_bus_master: single-outstanding command-to-register-bus master with response handshake.
// Optional bus-ready timeout is compiled in with REG_BUS_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
`default_nettype none

module reg_bus_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_sel,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic [7:0]        timeout_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_accept;
    logic                w_done;
    logic                w_timeout;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("reg_bus_master: TIMEOUT must be within 2..255");
    end

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_done   = bus_ready && (r_state == S_BUS);

`ifdef REG_BUS_MASTER_TIMEOUT_EN
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_wait;
    logic [7:0] r_tcnt;
    logic       r_err;

    // A ready on the final wait cycle wins over the timeout.
    assign w_timeout = (r_state == S_BUS) && !bus_ready && (r_wait == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= 8'd0;
            r_tcnt <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wait <= 8'd0;
            end else if ((r_state == S_BUS) && !bus_ready) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_timeout && (r_tcnt != 8'hFF)) begin
                r_tcnt <= r_tcnt + 8'd1;
            end
            if (w_done) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rsp_err     = r_err;
    assign timeout_cnt = r_tcnt;
`else
    assign w_timeout   = 1'b0;
    assign rsp_err     = 1'b0;
    assign timeout_cnt = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        bus_sel   = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = S_BUS;
                end
            end
            S_BUS: begin
                bus_sel = 1'b1;
                if (bus_ready || w_timeout) begin
                    w_next = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_wr    <= cmd_wr;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
            // Writes and timeouts report zero read data.
            if (w_done) begin
                r_rdata <= r_wr ? '0 : bus_rdata;
            end else if (w_timeout) begin
                r_rdata <= '0;
            end
        end
    end

    assign bus_wr    = bus_sel && r_wr;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign rsp_rdata = r_rdata;

endmodule

`default_nettype wire
